// File: rtl/pipefft_twid_pkg.sv
// Shared types and helpers for the pipelined-FFT twiddle store.
package pipefft_twid_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_e;

  localparam int RD_LAT_MAX = 3;

  // Negate a sign-extended comp_w-bit value; the most negative code clips to the most positive.
  function automatic logic signed [63:0] sat_neg(input logic signed [63:0] x, input int comp_w);
    logic signed [63:0] min_v;
    min_v = -(64'sd1 <<< (comp_w - 1));
    if (x == min_v) return -min_v - 64'sd1;
    return -x;
  endfunction

endpackage

// File: rtl/pipefft_twid_ram_sdp.sv
// Single-clock simple-dual-port RAM, read-first, one registered read stage.
module sdp_ram_rf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is reset; it holds its value between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pipefft_twid_ram_p.sv
// Twiddle-coefficient store: sequential/direct fill, RD_LAT-cycle read with optional conjugate.
// state | meaning:  IDLE | empty, await fill;  LOAD | sequential fill;  READY | table valid, reads on
module pipefft_twid_ram_p
  import pipefft_twid_pkg::*;
#(
  parameter int COMP_W = 16,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                LOAD_START,
  input  logic                LOAD_VALID,
  input  logic [2*COMP_W-1:0] LOAD_DATA,
  input  logic                WEN,
  input  logic [ADDR_W-1:0]   WADDR,
  input  logic [2*COMP_W-1:0] DI,
  input  logic                RD_EN,
  input  logic [ADDR_W-1:0]   RADDR,
  input  logic                CONJ,
  output logic                RD_VALID,
  output logic [2*COMP_W-1:0] DO,
  output logic                TABLE_RDY,
  output logic [ADDR_W:0]     LOAD_CNT
);

  localparam int DATA_W = 2 * COMP_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("pipefft_twid_ram_p: RD_LAT must be in 1..3");
  end

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic              vld_q [RD_LAT];
  logic              vld_d [RD_LAT];
  logic              conj_q [RD_LAT];
  logic              conj_d [RD_LAT];
  logic              load_wr, dir_wr, rd_acc;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata, out_dat;
  logic [COMP_W-1:0] neg_im;

  always_comb begin
    load_wr = (state_q == LOAD) && LOAD_VALID && !LOAD_START;
    dir_wr  = (state_q == READY) && WEN;
    rd_acc  = (state_q == READY) && RD_EN;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, READY: begin
        if (LOAD_START) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (LOAD_START) begin
          cnt_d = '0;
        end else if (load_wr) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == DEPTH_CNT) state_d = READY;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == READY);

    // Valid/CONJ travel with each request; CONJ holds between reads so DO stays stable.
    vld_d[0]  = rd_acc;
    conj_d[0] = rd_acc ? CONJ : conj_q[0];
    for (int k = 1; k < RD_LAT; k++) begin
      vld_d[k]  = vld_q[k-1];
      conj_d[k] = vld_q[k-1] ? conj_q[k-1] : conj_q[k];
    end

    ram_we    = load_wr || dir_wr;
    ram_waddr = load_wr ? cnt_q[ADDR_W-1:0] : WADDR;
    ram_wdata = load_wr ? LOAD_DATA : DI;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= '{default: 1'b0};
      conj_q  <= '{default: 1'b0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      conj_q  <= conj_d;
    end
  end

  sdp_ram_rf #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (CLK),
    .rst  (RST),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (rd_acc),
    .raddr(RADDR),
    .rdata(ram_rdata)
  );

  if (RD_LAT == 1) begin : g_lat1
    assign out_dat = ram_rdata;
  end else begin : g_latn
    logic [DATA_W-1:0] dat_q [RD_LAT-1];
    logic [DATA_W-1:0] dat_d [RD_LAT-1];

    always_comb begin
      dat_d[0] = vld_q[0] ? ram_rdata : dat_q[0];
      for (int k = 1; k < RD_LAT - 1; k++) begin
        dat_d[k] = vld_q[k] ? dat_q[k-1] : dat_q[k];
      end
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) dat_q <= '{default: '0};
      else     dat_q <= dat_d;
    end

    assign out_dat = dat_q[RD_LAT-2];
  end

  assign neg_im    = COMP_W'(sat_neg(64'(signed'(out_dat[DATA_W-1:COMP_W])), COMP_W));
  assign DO        = conj_q[RD_LAT-1] ? {neg_im, out_dat[COMP_W-1:0]} : out_dat;
  assign RD_VALID  = vld_q[RD_LAT-1];
  assign TABLE_RDY = rdy_q;
  assign LOAD_CNT  = cnt_q;

endmodule

// File: tb/tb_pipefft_twid_ram_p.sv
// Bench: three instances (RD_LAT 1/2/3) on shared stimulus, read results checked from a scoreboard queue.
module tb_pipefft_twid_ram_p;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        LOAD_START = 1'b0;
  logic        LOAD_VALID = 1'b0;
  logic [31:0] LOAD_DATA = '0;
  logic        WEN = 1'b0;
  logic [9:0]  WADDR = '0;
  logic [31:0] DI = '0;
  logic        RD_EN = 1'b0;
  logic [9:0]  RADDR = '0;
  logic        CONJ = 1'b0;

  logic        rdv  [3];
  logic [31:0] dout [3];
  logic        trdy [3];
  logic [10:0] lcnt [3];

  typedef struct {
    int          issue;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          rd_idx [3] = '{0, 0, 0};
  logic [31:0] last_exp [3] = '{32'h0, 32'h0, 32'h0};
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  pipefft_twid_ram_p #(.COMP_W(16), .ADDR_W(10), .RD_LAT(1)) u_lat1 (
    .CLK(CLK), .RST(RST), .LOAD_START(LOAD_START), .LOAD_VALID(LOAD_VALID), .LOAD_DATA(LOAD_DATA),
    .WEN(WEN), .WADDR(WADDR), .DI(DI), .RD_EN(RD_EN), .RADDR(RADDR), .CONJ(CONJ),
    .RD_VALID(rdv[0]), .DO(dout[0]), .TABLE_RDY(trdy[0]), .LOAD_CNT(lcnt[0]));

  pipefft_twid_ram_p #(.COMP_W(16), .ADDR_W(10), .RD_LAT(2)) u_lat2 (
    .CLK(CLK), .RST(RST), .LOAD_START(LOAD_START), .LOAD_VALID(LOAD_VALID), .LOAD_DATA(LOAD_DATA),
    .WEN(WEN), .WADDR(WADDR), .DI(DI), .RD_EN(RD_EN), .RADDR(RADDR), .CONJ(CONJ),
    .RD_VALID(rdv[1]), .DO(dout[1]), .TABLE_RDY(trdy[1]), .LOAD_CNT(lcnt[1]));

  pipefft_twid_ram_p #(.COMP_W(16), .ADDR_W(10), .RD_LAT(3)) u_lat3 (
    .CLK(CLK), .RST(RST), .LOAD_START(LOAD_START), .LOAD_VALID(LOAD_VALID), .LOAD_DATA(LOAD_DATA),
    .WEN(WEN), .WADDR(WADDR), .DI(DI), .RD_EN(RD_EN), .RADDR(RADDR), .CONJ(CONJ),
    .RD_VALID(rdv[2]), .DO(dout[2]), .TABLE_RDY(trdy[2]), .LOAD_CNT(lcnt[2]));

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Instance i must deliver each queued read exactly i+1 cycles after issue, in order.
  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (rdv[i] === 1'b1) begin
        n_assert++;
        if (rd_idx[i] >= exp_q.size()) begin
          n_fail++;
          $display("FAIL rd_valid_unexpected lat=%0d cyc=%0d got RD_VALID=1 want 0", i + 1, cyc);
        end else begin
          if ((exp_q[rd_idx[i]].issue + i + 1 != cyc) || (dout[i] !== exp_q[rd_idx[i]].data)) begin
            n_fail++;
            $display("FAIL read_data lat=%0d got DO=%h at cyc %0d want %h at cyc %0d", i + 1, dout[i], cyc,
                     exp_q[rd_idx[i]].data, exp_q[rd_idx[i]].issue + i + 1);
          end
          last_exp[i] = exp_q[rd_idx[i]].data;
          rd_idx[i]++;
        end
      end else if (rd_idx[i] < exp_q.size() && exp_q[rd_idx[i]].issue + i + 1 <= cyc) begin
        n_assert++;
        n_fail++;
        $display("FAIL read_missing lat=%0d cyc=%0d got RD_VALID=%b want 1 DO=%h", i + 1, cyc, rdv[i],
                 exp_q[rd_idx[i]].data);
        rd_idx[i]++;
      end else begin
        n_assert++;
        if (dout[i] !== last_exp[i]) begin
          n_fail++;
          $display("FAIL do_hold lat=%0d cyc=%0d got DO=%h want %h", i + 1, cyc, dout[i], last_exp[i]);
        end
      end
    end
    while (exp_q.size() > 0 && rd_idx[0] > 0 && rd_idx[1] > 0 && rd_idx[2] > 0) begin
      void'(exp_q.pop_front());
      for (int i = 0; i < 3; i++) rd_idx[i]--;
    end
  end

  task automatic drive_read(input logic [9:0] a, input logic c, input logic [31:0] exp_d);
    RD_EN = 1'b1;
    RADDR = a;
    CONJ  = c;
    exp_q.push_back('{cyc, exp_d});
  endtask

  task automatic drain();
    RD_EN = 1'b0;
    CONJ  = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      n_assert += 4;
      if (rdv[i] !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid lat=%0d got %b want 0", i + 1, rdv[i]); end
      if (dout[i] !== 32'h0) begin n_fail++; $display("FAIL reset_do lat=%0d got %h want 0", i + 1, dout[i]); end
      if (trdy[i] !== 1'b0) begin n_fail++; $display("FAIL reset_table_rdy lat=%0d got %b want 0", i + 1, trdy[i]); end
      if (lcnt[i] !== 11'd0) begin n_fail++; $display("FAIL reset_load_cnt lat=%0d got %0d want 0", i + 1, lcnt[i]); end
    end
    RST = 1'b0;
  endtask

  task automatic test_gating_idle();
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      RD_EN = 1'b1; RADDR = 10'(k);
      WEN = 1'b1; WADDR = 10'(k); DI = 32'hFFFF_FFFF;
      LOAD_VALID = 1'b1; LOAD_DATA = 32'h1111_1111;
    end
    @(negedge CLK);
    RD_EN = 1'b0; WEN = 1'b0; LOAD_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      n_assert += 2;
      if (lcnt[i] !== 11'd0) begin n_fail++; $display("FAIL idle_load_cnt lat=%0d got %0d want 0", i + 1, lcnt[i]); end
      if (trdy[i] !== 1'b0) begin n_fail++; $display("FAIL idle_table_rdy lat=%0d got %b want 0", i + 1, trdy[i]); end
    end
  endtask

  task automatic test_restart();
    @(negedge CLK);
    LOAD_START = 1'b1;
    for (int a = 0; a < 500; a++) begin
      @(negedge CLK);
      LOAD_START = 1'b0;
      LOAD_VALID = 1'b1; LOAD_DATA = 32'(a * 7 + 1);
      RD_EN = 1'b1; RADDR = 10'(a);
    end
    @(negedge CLK);
    RD_EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_assert += 2;
      if (lcnt[i] !== 11'd500) begin n_fail++; $display("FAIL partial_load_cnt lat=%0d got %0d want 500", i + 1, lcnt[i]); end
      if (trdy[i] !== 1'b0) begin n_fail++; $display("FAIL partial_table_rdy lat=%0d got %b want 0", i + 1, trdy[i]); end
    end
    LOAD_START = 1'b1; LOAD_VALID = 1'b1; LOAD_DATA = 32'hDEAD_BEEF;
    @(negedge CLK);
    LOAD_START = 1'b0; LOAD_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_assert++;
      if (lcnt[i] !== 11'd0) begin n_fail++; $display("FAIL restart_load_cnt lat=%0d got %0d want 0", i + 1, lcnt[i]); end
    end
  endtask

  task automatic test_fill();
    int a;
    a = 0;
    @(negedge CLK);
    LOAD_START = 1'b1;
    while (a < 1024) begin
      @(negedge CLK);
      LOAD_START = 1'b0;
      if (a > 0 && $urandom_range(7) == 0) begin
        LOAD_VALID = 1'b0;
        WEN = (a > 600); WADDR = 10'd3; DI = 32'hFFFF_FFFF;
      end else begin
        WEN = 1'b0;
        LOAD_VALID = 1'b1; LOAD_DATA = 32'(a * 3);
        if (a == 1023) begin
          for (int i = 0; i < 3; i++) begin
            n_assert += 2;
            if (lcnt[i] !== 11'd1023) begin n_fail++; $display("FAIL fill_cnt_last lat=%0d got %0d want 1023", i + 1, lcnt[i]); end
            if (trdy[i] !== 1'b0) begin n_fail++; $display("FAIL fill_rdy_early lat=%0d got %b want 0", i + 1, trdy[i]); end
          end
        end
        a++;
      end
    end
    @(negedge CLK);
    LOAD_VALID = 1'b0; WEN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_assert += 2;
      if (trdy[i] !== 1'b1) begin n_fail++; $display("FAIL fill_table_rdy lat=%0d got %b want 1", i + 1, trdy[i]); end
      if (lcnt[i] !== 11'd1024) begin n_fail++; $display("FAIL fill_load_cnt lat=%0d got %0d want 1024", i + 1, lcnt[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] addrs [6] = '{10'd5, 10'd6, 10'd7, 10'd0, 10'd3, 10'd1023};
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      drive_read(addrs[k], 1'b0, 32'(addrs[k]) * 32'd3);
    end
    @(negedge CLK);
    drain();
  endtask

  task automatic test_conj();
    @(negedge CLK); WEN = 1'b1; WADDR = 10'd9;  DI = {16'h8000, 16'h1234};
    @(negedge CLK); WADDR = 10'd10; DI = {16'h0005, 16'h1234};
    @(negedge CLK); WADDR = 10'd11; DI = {16'h7FFF, 16'h8000};
    @(negedge CLK); WEN = 1'b0;
    drive_read(10'd9, 1'b1, {16'h7FFF, 16'h1234});
    @(negedge CLK); drive_read(10'd10, 1'b1, {16'hFFFB, 16'h1234});
    @(negedge CLK); drive_read(10'd10, 1'b0, {16'h0005, 16'h1234});
    @(negedge CLK); drive_read(10'd11, 1'b1, {16'h8001, 16'h8000});
    @(negedge CLK); drive_read(10'd6, 1'b1, {16'h0000, 16'd18});
    @(negedge CLK);
    drain();
  endtask

  task automatic test_collision();
    @(negedge CLK);
    WEN = 1'b1; WADDR = 10'd20; DI = 32'h0000_00AA;
    drive_read(10'd20, 1'b0, 32'd60);
    @(negedge CLK);
    WEN = 1'b0;
    drive_read(10'd20, 1'b0, 32'h0000_00AA);
    @(negedge CLK);
    drain();
  endtask

  task automatic test_ready_gating();
    @(negedge CLK);
    LOAD_VALID = 1'b1; LOAD_DATA = 32'h5555_5555;
    @(negedge CLK);
    LOAD_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_assert += 2;
      if (lcnt[i] !== 11'd1024) begin n_fail++; $display("FAIL ready_load_cnt lat=%0d got %0d want 1024", i + 1, lcnt[i]); end
      if (trdy[i] !== 1'b1) begin n_fail++; $display("FAIL ready_table_rdy lat=%0d got %b want 1", i + 1, trdy[i]); end
    end
    drive_read(10'd0, 1'b0, 32'd0);
    @(negedge CLK);
    drain();
  endtask

  task automatic test_inflight_load();
    @(negedge CLK); drive_read(10'd5, 1'b0, 32'd15);
    @(negedge CLK); drive_read(10'd6, 1'b0, 32'd18);
    @(negedge CLK); drive_read(10'd7, 1'b0, 32'd21);
    @(negedge CLK);
    RD_EN = 1'b0; LOAD_START = 1'b1;
    @(negedge CLK);
    LOAD_START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_assert++;
      if (trdy[i] !== 1'b0) begin n_fail++; $display("FAIL inflight_table_rdy lat=%0d got %b want 0", i + 1, trdy[i]); end
    end
    drain();
  endtask

  task automatic test_reset_mid_read();
    @(negedge CLK); drive_read(10'd5, 1'b0, 32'd15);
    @(negedge CLK); drive_read(10'd6, 1'b0, 32'd18);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_assert += 4;
      if (rdv[i] !== 1'b0) begin n_fail++; $display("FAIL midreset_rd_valid lat=%0d got %b want 0", i + 1, rdv[i]); end
      if (dout[i] !== 32'h0) begin n_fail++; $display("FAIL midreset_do lat=%0d got %h want 0", i + 1, dout[i]); end
      if (trdy[i] !== 1'b0) begin n_fail++; $display("FAIL midreset_table_rdy lat=%0d got %b want 0", i + 1, trdy[i]); end
      if (lcnt[i] !== 11'd0) begin n_fail++; $display("FAIL midreset_load_cnt lat=%0d got %0d want 0", i + 1, lcnt[i]); end
    end
    exp_q.delete();
    rd_idx = '{0, 0, 0};
    last_exp = '{32'h0, 32'h0, 32'h0};
    RD_EN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RD_EN = 1'b1; RADDR = 10'd5;
    repeat (3) @(negedge CLK);
    drain();
  endtask

  initial begin
    test_reset();
    test_gating_idle();
    test_restart();
    test_fill();
    test_back_to_back();
    test_conj();
    test_collision();
    test_ready_gating();
    test_inflight_load();
    test_fill();
    test_reset_mid_read();
    test_fill();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
